bnn_img_loader: RTL and testbench

Input stage that sits directly upstream of BNN_Network and produces its flat binary image vector `buff`. It accepts a 30x30 binary image as a stream of narrow beats under a valid/ready handshake and packs the beats into a 900-bit frame buffer. When the frame is complete it presents the buffer as stable with `buff_valid`, and holds it until the consumer acknowledges.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_img_loader.sv | 95 +++++++++
 tb/tb_bnn_img_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN constants and the image loader state encoding.
// BNN_Network imports IMG_SIZE from here so the loader and network widths always match.
package bnn_pkg;

   localparam int IMG_WIDTH = 30;
   localparam int IMG_SIZE  = IMG_WIDTH * IMG_WIDTH;
   localparam int IN_WIDTH  = 8;
   localparam int NUM_BEATS = (IMG_SIZE + IN_WIDTH - 1) / IN_WIDTH;
   localparam int CNT_W     = $clog2(NUM_BEATS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } ldr_state_e;

endpackage

// File: rtl/bnn_img_loader.sv
// Packs a stream of IN_WIDTH-pixel beats into the flat IMG_SIZE-bit image for BNN_Network
// and holds the completed frame until the consumer acknowledges it.
module bnn_img_loader
   import bnn_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [IN_WIDTH-1:0] in_data,
   input  logic                in_sof,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [IMG_SIZE-1:0] buff,
   output logic                buff_valid,
   input  logic                buff_ack,
   output logic                frame_err
);

   ldr_state_e          state, state_next;
   logic [CNT_W-1:0]    beat_cnt, cnt_next;
   logic [CNT_W-1:0]    wr_idx;
   logic                wr_en;
   logic                err_next;
   logic                accept;
   logic [IMG_SIZE-1:0] buff_next;

   assign in_ready   = (state != FULL);
   assign buff_valid = (state == FULL);
   assign accept     = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         buff      <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         beat_cnt  <= cnt_next;
         buff      <= buff_next;
         frame_err <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = beat_cnt;
      wr_en      = 1'b0;
      wr_idx     = beat_cnt;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (in_sof) begin
                  wr_en      = 1'b1;
                  wr_idx     = '0;
                  cnt_next   = CNT_W'(1);
                  state_next = LOAD;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               if (in_sof) begin
                  // early restart: the partial frame is abandoned, new data lands at slice 0
                  wr_idx   = '0;
                  cnt_next = CNT_W'(1);
                  err_next = 1'b1;
               end else if (beat_cnt == CNT_W'(NUM_BEATS - 1)) begin
                  cnt_next   = '0;
                  state_next = FULL;
               end else begin
                  cnt_next = beat_cnt + CNT_W'(1);
               end
            end
         end
         FULL: begin
            if (buff_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One decoded enable per beat slice; the last slice keeps only the in-range pixels.
   for (genvar k = 0; k < NUM_BEATS; k++) begin : g_slice
      localparam int LO = k * IN_WIDTH;
      localparam int NB = (IMG_SIZE - LO < IN_WIDTH) ? (IMG_SIZE - LO) : IN_WIDTH;
      logic slice_we;
      assign slice_we = wr_en && (wr_idx == CNT_W'(k));
      assign buff_next[LO +: NB] = slice_we ? in_data[NB-1:0] : buff[LO +: NB];
   end

endmodule

// File: tb/tb_bnn_img_loader.sv
// Scoreboard bench for bnn_img_loader: stimulus queues expected frames, a monitor
// compares them when buff_valid rises; directed checks cover timing and framing errors.
module tb_bnn_img_loader;
   import bnn_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic [IN_WIDTH-1:0] in_data;
   logic                in_sof;
   logic                in_valid;
   logic                in_ready;
   logic [IMG_SIZE-1:0] buff;
   logic                buff_valid;
   logic                buff_ack;
   logic                frame_err;

   int n_chk  = 0;
   int n_fail = 0;
   int err_seen = 0;
   int exp_err  = 0;
   logic [IMG_SIZE-1:0] exp_frames[$];
   logic [IMG_SIZE-1:0] f0, f1;

   always #5 clk = ~clk;

   bnn_img_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .buff      (buff),
      .buff_valid(buff_valid),
      .buff_ack  (buff_ack),
      .frame_err (frame_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_buf(input string nm, input logic [IMG_SIZE-1:0] act, input logic [IMG_SIZE-1:0] exp);
      int first;
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         first = -1;
         for (int i = IMG_SIZE - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
         $display("FAIL %s: first differing bit %0d got %b expected %b", nm, first, act[first], exp[first]);
      end
   endtask

   function automatic logic [7:0] pat(input int mode, input int k);
      logic [7:0] kb;
      kb = 8'(k);
      case (mode)
         0: return kb;
         1: return kb + 8'h80;
         2: return ~kb;
         3: return kb ^ 8'h5A;
         default: return 8'hC3;
      endcase
   endfunction

   function automatic logic [IMG_SIZE-1:0] mk_frame(input int mode);
      logic [IMG_SIZE-1:0] f;
      logic [7:0] b;
      f = '0;
      for (int k = 0; k < NUM_BEATS; k++) begin
         b = pat(mode, k);
         for (int j = 0; j < IN_WIDTH; j++)
            if (k * IN_WIDTH + j < IMG_SIZE) f[k * IN_WIDTH + j] = b[j];
      end
      return f;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send_beat(input logic [7:0] d, input logic s);
      int guard;
      guard = 0;
      in_data  = d;
      in_sof   = s;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (in_ready !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready got %b expected 1", in_ready);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int mode, input bit gaps, input bit restart);
      exp_frames.push_back(mk_frame(mode));
      for (int k = 0; k < NUM_BEATS; k++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         if (k == NUM_BEATS - 1) chk("valid_before_last", {31'd0, buff_valid}, 32'd0);
         send_beat(pat(mode, k), k == 0);
         if (k == 0 && restart) begin
            chk("restart_err", {31'd0, frame_err}, 32'd1);
            chk("restart_slice0", {24'd0, buff[7:0]}, {24'd0, pat(mode, 0)});
         end
      end
      chk("valid_after_last", {31'd0, buff_valid}, 32'd1);
   endtask

   task automatic do_ack();
      in_valid = 1'b0;
      buff_ack = 1'b1;
      @(posedge clk); #1;
      buff_ack = 1'b0;
      chk("ack_valid_low", {31'd0, buff_valid}, 32'd0);
      chk("ack_ready_high", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic chk_err_count(input string nm);
      @(negedge clk); #1;
      chk(nm, err_seen, exp_err);
      @(posedge clk); #1;
   endtask

   // Monitor: frame_err pulse counter and frame scoreboard on buff_valid rising edge.
   initial begin
      logic prev_bv;
      logic [IMG_SIZE-1:0] e;
      prev_bv = 1'b0;
      forever begin
         @(negedge clk);
         if (frame_err === 1'b1) err_seen++;
         if (buff_valid === 1'b1 && prev_bv !== 1'b1) begin
            if (exp_frames.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_frame: buff_valid rose with no frame queued");
            end else begin
               e = exp_frames.pop_front();
               chk_buf("frame_data", buff, e);
            end
         end
         prev_bv = buff_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_data = '0; in_sof = 1'b0; in_valid = 1'b0; buff_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_buff_zero", {31'd0, buff == '0}, 32'd1);
      chk("rst_valid", {31'd0, buff_valid}, 32'd0);
      chk("rst_err", {31'd0, frame_err}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // nominal frame, beat k = k
      f0 = mk_frame(0);
      send_frame(0, 1'b0, 1'b0);
      chk("nom_byte0", {24'd0, buff[7:0]}, 32'h00);
      chk("nom_byte1", {24'd0, buff[15:8]}, 32'h01);
      chk("nom_byte50", {24'd0, buff[407:400]}, 32'h32);
      chk("nom_tail", {28'd0, buff[899:896]}, 32'h0);
      chk_err_count("nom_err_count");

      // backpressure in FULL
      in_data = 8'hFF; in_sof = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
         chk("bp_valid_high", {31'd0, buff_valid}, 32'd1);
         chk_buf("bp_buff_held", buff, f0);
      end
      do_ack();
      chk_buf("ack_buff_kept", buff, f0);
      chk_err_count("bp_err_count");

      // early restart on beat 50
      for (int k = 0; k < 50; k++) send_beat(8'hC3, k == 0);
      chk("partial_byte49", {24'd0, buff[399:392]}, 32'hC3);
      exp_err++;
      send_frame(1, 1'b0, 1'b1);
      chk_err_count("restart_err_count");
      f1 = mk_frame(1);
      do_ack();

      // stray beats in IDLE, back to back
      send_beat(8'hAA, 1'b0);
      chk("stray_err1", {31'd0, frame_err}, 32'd1);
      chk_buf("stray_buff_kept", buff, f1);
      chk("stray_ready", {31'd0, in_ready}, 32'd1);
      send_beat(8'h55, 1'b0);
      chk("stray_err2", {31'd0, frame_err}, 32'd1);
      exp_err += 2;
      @(posedge clk); #1;
      chk("stray_err_clear", {31'd0, frame_err}, 32'd0);
      chk_buf("stray2_buff_kept", buff, f1);
      send_frame(2, 1'b0, 1'b0);
      chk_err_count("stray_err_count");
      do_ack();

      // reset after 60 beats
      for (int k = 0; k < 60; k++) send_beat(pat(4, k), k == 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_buff_zero", {31'd0, buff == '0}, 32'd1);
      chk("midrst_valid", {31'd0, buff_valid}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_err", {31'd0, frame_err}, 32'd0);
      send_frame(3, 1'b0, 1'b0);
      chk_err_count("midrst_err_count");
      do_ack();

      // throttled nominal frame must match the gap-free one
      send_frame(0, 1'b1, 1'b0);
      chk_buf("throttled_buff", buff, f0);
      do_ack();
      repeat (3) @(posedge clk);
      #1;
      chk("frames_pending", exp_frames.size(), 32'd0);
      chk_err_count("final_err_count");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
